// File: rtl/line_buffer_5row_pkg.sv
// Shared video definitions for the line buffer and the 5x5 convolution stage.
package line_buffer_5row_pkg;

  localparam int DEF_COLORDEPTH  = 8;
  localparam int DEF_SCREENWIDTH = 1600;
  // col_cnt has to be able to hold SCREENWIDTH itself (saturation value)
  localparam int DEF_ADDRW       = $clog2(DEF_SCREENWIDTH + 1);
  localparam int KERNEL_ROWS     = 5;
  localparam int HIST_ROWS       = KERNEL_ROWS - 1;

  function automatic logic [2:0] line_cnt_inc(input logic [2:0] cnt);
    return (cnt >= 3'(HIST_ROWS)) ? cnt : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module sdp_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1600,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr[IW-1:0]] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr[IW-1:0]];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_buffer_5row.sv
// Stores the 4 previous video lines and emits a vertically aligned 5-pixel column,
// with syncs re-timed by 2 cycles and rows above the frame top masked to zero.
module line_buffer_5row
  import line_buffer_5row_pkg::*;
#(
  parameter int COLORDEPTH  = DEF_COLORDEPTH,
  parameter int SCREENWIDTH = DEF_SCREENWIDTH,
  parameter int ADDRW       = DEF_ADDRW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] pix_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [COLORDEPTH-1:0] vect_out_0,
  output logic [COLORDEPTH-1:0] vect_out_1,
  output logic [COLORDEPTH-1:0] vect_out_2,
  output logic [COLORDEPTH-1:0] vect_out_3,
  output logic [COLORDEPTH-1:0] vect_out_4,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o
);

  localparam int WORDW = HIST_ROWS * COLORDEPTH;

  logic [ADDRW-1:0]      col_cnt_q, col_cnt_d;
  logic [2:0]            line_cnt_q, line_cnt_d;

  logic [COLORDEPTH-1:0] pix_s1_q, pix_s1_d;
  logic [ADDRW-1:0]      addr_s1_q, addr_s1_d;
  logic                  wr_en_s1_q, wr_en_s1_d;
  logic [HIST_ROWS-1:0]  mask_s1_q, mask_s1_d;
  logic                  dv_s1_q, dv_s1_d;
  logic                  hs_s1_q, hs_s1_d;
  logic                  vs_s1_q, vs_s1_d;

  logic [COLORDEPTH-1:0] out_q [KERNEL_ROWS];
  logic [COLORDEPTH-1:0] out_d [KERNEL_ROWS];
  logic                  dv_o_q, dv_o_d;
  logic                  hs_o_q, hs_o_d;
  logic                  vs_o_q, vs_o_d;

  logic                  overflow;
  logic [ADDRW-1:0]      rd_addr;
  logic [WORDW-1:0]      rd_word;
  logic [WORDW-1:0]      wr_word;

  always_comb begin
    overflow = dv_i && (col_cnt_q == ADDRW'(SCREENWIDTH));

    col_cnt_d = '0;
    if (dv_i) begin
      col_cnt_d = overflow ? col_cnt_q : col_cnt_q + 1'b1;
    end

    // dv_s1_q doubles as the previous-cycle dv for falling-edge detection
    line_cnt_d = line_cnt_q;
    if (vs_i) begin
      line_cnt_d = '0;
    end else if (dv_s1_q && !dv_i) begin
      line_cnt_d = line_cnt_inc(line_cnt_q);
    end

    rd_addr    = overflow ? '0 : col_cnt_q;
    pix_s1_d   = dv_i ? pix_i : '0;
    addr_s1_d  = col_cnt_q;
    wr_en_s1_d = dv_i && !overflow;
    for (int k = 0; k < HIST_ROWS; k++) begin
      mask_s1_d[k] = wr_en_s1_d && (line_cnt_q > 3'(k));
    end
    dv_s1_d = dv_i;
    hs_s1_d = hs_i;
    vs_s1_d = vs_i;

    // oldest line drops off the top, current pixel becomes line-1
    wr_word  = {rd_word[WORDW-COLORDEPTH-1:0], pix_s1_q};
    out_d[0] = pix_s1_q;
    for (int k = 1; k < KERNEL_ROWS; k++) begin
      out_d[k] = mask_s1_q[k-1] ? rd_word[(k-1)*COLORDEPTH +: COLORDEPTH] : '0;
    end
    dv_o_d = dv_s1_q;
    hs_o_d = hs_s1_q;
    vs_o_d = vs_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q  <= '0;
      line_cnt_q <= '0;
      pix_s1_q   <= '0;
      addr_s1_q  <= '0;
      wr_en_s1_q <= 1'b0;
      mask_s1_q  <= '0;
      dv_s1_q    <= 1'b0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      for (int k = 0; k < KERNEL_ROWS; k++) begin
        out_q[k] <= '0;
      end
      dv_o_q     <= 1'b0;
      hs_o_q     <= 1'b0;
      vs_o_q     <= 1'b0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      line_cnt_q <= line_cnt_d;
      pix_s1_q   <= pix_s1_d;
      addr_s1_q  <= addr_s1_d;
      wr_en_s1_q <= wr_en_s1_d;
      mask_s1_q  <= mask_s1_d;
      dv_s1_q    <= dv_s1_d;
      hs_s1_q    <= hs_s1_d;
      vs_s1_q    <= vs_s1_d;
      for (int k = 0; k < KERNEL_ROWS; k++) begin
        out_q[k] <= out_d[k];
      end
      dv_o_q     <= dv_o_d;
      hs_o_q     <= hs_o_d;
      vs_o_q     <= vs_o_d;
    end
  end

  sdp_ram #(
    .DW    (WORDW),
    .DEPTH (SCREENWIDTH),
    .AW    (ADDRW)
  ) u_line_ram (
    .clk     (clk),
    .we      (wr_en_s1_q),
    .wr_addr (addr_s1_q),
    .wr_data (wr_word),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  assign vect_out_0 = out_q[0];
  assign vect_out_1 = out_q[1];
  assign vect_out_2 = out_q[2];
  assign vect_out_3 = out_q[3];
  assign vect_out_4 = out_q[4];
  assign dv_o       = dv_o_q;
  assign hs_o       = hs_o_q;
  assign vs_o       = vs_o_q;

endmodule

// File: tb/tb_line_buffer_5row.sv
// Randomized bench for line_buffer_5row against a per-column line-history model.
module tb_line_buffer_5row;

  localparam int CD = 8;
  localparam int SW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CD-1:0] pix_i;
  logic          dv_i, hs_i, vs_i;
  logic [CD-1:0] vect_out_0, vect_out_1, vect_out_2, vect_out_3, vect_out_4;
  logic          dv_o, hs_o, vs_o;

  always #5 clk = ~clk;

  line_buffer_5row #(
    .COLORDEPTH  (CD),
    .SCREENWIDTH (SW),
    .ADDRW       (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_i      (pix_i),
    .dv_i       (dv_i),
    .hs_i       (hs_i),
    .vs_i       (vs_i),
    .vect_out_0 (vect_out_0),
    .vect_out_1 (vect_out_1),
    .vect_out_2 (vect_out_2),
    .vect_out_3 (vect_out_3),
    .vect_out_4 (vect_out_4),
    .dv_o       (dv_o),
    .hs_o       (hs_o),
    .vs_o       (vs_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: each column keeps its last 4 pixels (newest first); the number of
  // completed lines since vs decides how many of them are visible.
  logic [CD-1:0] hist [SW][4];
  int            m_col;
  int            m_lines;
  bit            m_dv_prev;
  logic [CD-1:0] e_pix  [2][5];
  logic [2:0]    e_sync [2];

  task automatic model_edge();
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 5; k++) e_pix[s][k] = '0;
        e_sync[s] = '0;
      end
      m_col     = 0;
      m_lines   = 0;
      m_dv_prev = 1'b0;
      return;
    end
    e_pix[1]  = e_pix[0];
    e_sync[1] = e_sync[0];
    e_sync[0] = {dv_i, hs_i, vs_i};
    for (int k = 0; k < 5; k++) e_pix[0][k] = '0;
    if (dv_i) begin
      e_pix[0][0] = pix_i;
      if (m_col < SW) begin
        for (int k = 1; k < 5; k++) begin
          if (m_lines >= k) e_pix[0][k] = hist[m_col][k-1];
        end
        for (int j = 3; j > 0; j--) hist[m_col][j] = hist[m_col][j-1];
        hist[m_col][0] = pix_i;
      end
    end
    if (dv_i) m_col = (m_col < SW) ? m_col + 1 : m_col;
    else      m_col = 0;
    if (vs_i) m_lines = 0;
    else if (m_dv_prev && !dv_i && m_lines < 4) m_lines++;
    m_dv_prev = dv_i;
  endtask

  task automatic step(input bit r, input bit d, input bit h, input bit v, input logic [CD-1:0] p);
    rst   = r;
    dv_i  = d;
    hs_i  = h;
    vs_i  = v;
    pix_i = p;
    @(posedge clk);
    model_edge();
    #1;
    check("vect_out_0", vect_out_0, e_pix[1][0]);
    check("vect_out_1", vect_out_1, e_pix[1][1]);
    check("vect_out_2", vect_out_2, e_pix[1][2]);
    check("vect_out_3", vect_out_3, e_pix[1][3]);
    check("vect_out_4", vect_out_4, e_pix[1][4]);
    check("dv_o", dv_o, e_sync[1][2]);
    check("hs_o", hs_o, e_sync[1][1]);
    check("vs_o", vs_o, e_sync[1][0]);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic vsync();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(2);
  endtask

  task automatic hblank();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rand_line(input int len);
    for (int c = 0; c < len; c++) step(1'b0, 1'b1, 1'b0, 1'b0, CD'($urandom));
    hblank();
  endtask

  int dv_seen;

  initial begin
    for (int c = 0; c < SW; c++)
      for (int j = 0; j < 4; j++) hist[c][j] = '0;
    m_col = 0; m_lines = 0; m_dv_prev = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 5; k++) e_pix[s][k] = '0;
      e_sync[s] = '0;
    end

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("reset_dv_o", dv_o, 1'b0);
    idle(4);

    // frame of ramps: pix = 16*line + col
    vsync();
    for (int l = 0; l < 6; l++) begin
      dv_seen = 0;
      for (int c = 0; c < SW; c++) begin
        step(1'b0, 1'b1, 1'b0, 1'b0, CD'(16 * l + c));
        dv_seen += int'(dv_o);
        if (l == 1 && c == 0) check("latency_pre", vect_out_0, 0);
        if (l == 1 && c == 1) check("latency_first", vect_out_0, 16);
        if (l == 2 && c == 4) begin
          check("border_r0", vect_out_0, 35);
          check("border_r1", vect_out_1, 19);
          check("border_r2", vect_out_2, 3);
          check("border_r3", vect_out_3, 0);
          check("border_r4", vect_out_4, 0);
        end
        if (l == 5 && c == 4) begin
          check("stack_r0", vect_out_0, 83);
          check("stack_r1", vect_out_1, 67);
          check("stack_r2", vect_out_2, 51);
          check("stack_r3", vect_out_3, 35);
          check("stack_r4", vect_out_4, 19);
        end
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      dv_seen += int'(dv_o);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      dv_seen += int'(dv_o);
      check("dv_o_width", dv_seen, SW);
    end

    // new frame re-masks rows 1..4 although the RAM is full
    vsync();
    for (int c = 0; c < SW; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, CD'(8'hA0 + c));
      if (c == 4) check("remask_r1", vect_out_1, 0);
    end
    hblank();
    for (int l = 0; l < 5; l++) rand_line(SW);

    // overflow lines
    vsync();
    for (int l = 0; l < 3; l++) rand_line(SW + 2);
    for (int l = 0; l < 2; l++) rand_line(SW);

    // reset in the middle of a line
    vsync();
    for (int l = 0; l < 3; l++) rand_line(SW);
    for (int c = 0; c < SW; c++) begin
      step(c == 4, 1'b1, 1'b0, 1'b0, CD'($urandom));
      if (c == 4) begin
        check("midrst_r0", vect_out_0, 0);
        check("midrst_r1", vect_out_1, 0);
        check("midrst_dv", dv_o, 0);
      end
    end
    hblank();
    for (int l = 0; l < 3; l++) rand_line(SW);
    vsync();
    for (int l = 0; l < 5; l++) rand_line(SW);

    // free-running random stream with occasional vs and reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 97) == 0, ($urandom % 5) != 0, ($urandom % 7) == 0,
           ($urandom % 41) == 0, CD'($urandom));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
